alu32_ex_stage: RTL and testbench

ALU32_EX_STAGE -- requirements
Module: alu32_ex_stage

---
 rtl/alu32_ex_stage.sv | 71 +++++++
 tb/tb_alu32_ex_stage.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/alu32_ex_stage.sv
// alu32_ex_stage: two-stage AND/OR/SUM/SLT ALU with valid/ready handshake; define ALU32_EX_STAGE_OVF_EN to build the ovf flag
module alu32_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  alu_op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        zero,
  output logic        ovf
);
  logic        s1_valid_q, s2_valid_q, zero_q, s1_adv, slt, sub_ovf;
  logic [31:0] a_q, b_q, result_q, result_d, bb, sum, diff;
  logic [2:0]  op_q;
  assign s1_adv    = !s2_valid_q || out_ready;
  assign in_ready  = !s1_valid_q || s1_adv;
  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  // S1 -> S2 datapath; slt always uses a true subtract so it ignores binvert
  always_comb begin
    bb       = op_q[2] ? ~b_q + 32'd1 : b_q;
    sum      = a_q + bb;
    diff     = a_q - b_q;
    sub_ovf  = (a_q[31] != b_q[31]) && (diff[31] != a_q[31]);
    slt      = diff[31] ^ sub_ovf;
    result_d = op_q[1] ? (op_q[0] ? {31'b0, slt} : sum) : (op_q[0] ? a_q | b_q : a_q & b_q);
  end
  // S1 operand register; takes a new bundle (or empties) whenever it has room
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        a_q  <= a;
        b_q  <= b;
        op_q <= alu_op;
      end
    end
  // S2 result register; holds while the consumer stalls
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
    end else if (s1_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        result_q <= result_d;
        zero_q   <= result_d == '0;
      end
    end
`ifdef ALU32_EX_STAGE_OVF_EN
  logic ovf_q;
  // Signed overflow of SUM: same-sign operands producing an opposite-sign sum
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf_q <= 1'b0;
    else if (s1_adv && s1_valid_q) ovf_q <= op_q[1:0] == 2'b10 && a_q[31] == bb[31] && sum[31] != a_q[31];
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_alu32_ex_stage.sv
// tb_alu32_ex_stage: table vectors plus scoreboarded streaming, backpressure and reset sequences
module tb_alu32_ex_stage;
`ifdef ALU32_EX_STAGE_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] res;
    logic        zero;
    logic        ovf;
  } vec_t;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1, ord = 1'b1;
  logic        in_ready, out_valid, zero, ovf;
  logic [31:0] a = '0, b = '0, result;
  logic [2:0]  alu_op = '0;
  int          checks = 0, errors = 0;
  vec_t        sb[$];
  logic        stall_q = 1'b0, held_zero, held_ovf;
  logic [31:0] held_res;
  alu32_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_op(alu_op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic vec_t mk(input logic [31:0] x, input logic [31:0] y, input logic [2:0] op);
    vec_t t;
    logic [31:0] yb;
    longint s;
    t.a = x;
    t.b = y;
    t.op = op;
    yb = op[2] ? ~y + 32'd1 : y;
    case (op[1:0])
      2'b00:   t.res = x & y;
      2'b01:   t.res = x | y;
      2'b10:   t.res = x + yb;
      default: t.res = {31'b0, $signed(x) < $signed(y)};
    endcase
    s = longint'($signed(x)) + longint'($signed(yb));
    t.ovf = OVF && op[1:0] == 2'b10 && (s > 64'sd2147483647 || s < -64'sd2147483648);
    t.zero = t.res == 32'd0;
    return t;
  endfunction
  task automatic drive(input logic v, input vec_t t, output bit acc);
    @(posedge clk);
    #1;
    in_valid = v;
    a = t.a;
    b = t.b;
    alu_op = t.op;
    out_ready = ord;
    @(negedge clk);
    acc = v && in_ready;
    if (acc) sb.push_back(t);
  endtask
  always @(negedge clk) begin : mon
    vec_t e;
    if (!rst_n) stall_q = 1'b0;
    else begin
      if (stall_q) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_result", result, held_res);
        chk("hold_zero", zero, held_zero);
        chk("hold_ovf", ovf, held_ovf);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_output", out_valid, 0);
        else begin
          e = sb.pop_front();
          chk("result", result, e.res);
          chk("zero", zero, e.zero);
          chk("ovf", ovf, e.ovf);
        end
      end
      stall_q = out_valid && !out_ready;
      held_res = result;
      held_zero = zero;
      held_ovf = ovf;
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "timeout");
  end
  initial begin
    vec_t tab[10];
    vec_t idle, v3;
    bit acc;
    int tries;
    tab[0] = '{32'h11111111, 32'h22222222, 3'b000, 32'h00000000, 1'b1, 1'b0};
    tab[1] = '{32'h11111111, 32'h22222222, 3'b001, 32'h33333333, 1'b0, 1'b0};
    tab[2] = '{32'h11111111, 32'h22222222, 3'b010, 32'h33333333, 1'b0, 1'b0};
    tab[3] = '{32'h22222222, 32'h11111111, 3'b110, 32'h11111111, 1'b0, 1'b0};
    tab[4] = '{32'hFFFFFFFF, 32'h00000001, 3'b111, 32'h00000001, 1'b0, 1'b0};
    tab[5] = '{32'h7FFFFFFF, 32'h80000000, 3'b111, 32'h00000000, 1'b1, 1'b0};
    tab[6] = '{32'h7FFFFFFF, 32'h00000001, 3'b010, 32'h80000000, 1'b0, OVF};
    tab[7] = '{32'h7FFFFFFF, 32'h00000001, 3'b000, 32'h00000001, 1'b0, 1'b0};
    tab[8] = '{32'h80000000, 32'h00000001, 3'b110, 32'h7FFFFFFF, 1'b0, OVF};
    tab[9] = '{32'h80000000, 32'h7FFFFFFF, 3'b011, 32'h00000001, 1'b0, 1'b0};
    idle = mk(32'd0, 32'd0, 3'b000);
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_release_in_ready", in_ready, 1);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, tab[i], acc);
      chk("tab_accept", acc, 1);
    end
    repeat (4) drive(1'b0, idle, acc);
    chk("tab_drained", sb.size(), 0);
    for (int k = 0; k < 14; k++) begin
      drive(k < 10, mk($urandom, $urandom, 3'($urandom_range(0, 7))), acc);
      if (k < 10) chk("stream_accept", acc, 1);
      chk("stream_out_valid", out_valid, k >= 2 && k < 12);
    end
    chk("stream_drained", sb.size(), 0);
    ord = 1'b0;
    drive(1'b1, mk(32'h5, 32'h3, 3'b010), acc);
    chk("bp_accept1", acc, 1);
    drive(1'b1, mk(32'h9, 32'h4, 3'b110), acc);
    chk("bp_accept2", acc, 1);
    v3 = mk(32'hA5A5A5A5, 32'h0F0F0F0F, 3'b001);
    drive(1'b1, v3, acc);
    chk("bp_full_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    drive(1'b1, v3, acc);
    chk("bp_full_in_ready2", in_ready, 0);
    ord = 1'b1;
    tries = 0;
    do begin
      drive(1'b1, v3, acc);
      tries++;
    end while (!acc && tries < 4);
    chk("bp_accept3", acc, 1);
    repeat (5) drive(1'b0, idle, acc);
    chk("bp_drained", sb.size(), 0);
    drive(1'b1, mk(32'd1, 32'd2, 3'b010), acc);
    drive(1'b1, mk(32'd3, 32'd4, 3'b010), acc);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result", result, 0);
    chk("midrst_zero", zero, 0);
    chk("midrst_in_ready", in_ready, 1);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_release_in_ready", in_ready, 1);
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, idle, acc);
      chk("midrst_no_stale", out_valid, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
